// File: rtl/find_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | find_sched_pkg                                                        |
// | Shared state encoding and result-entry sizing for the find scheduler. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package find_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int unit_width(input int units);
        return (units > 1) ? $clog2(units) : 1;
    endfunction

    // Result entry is packed {unit, seq, e}
    function automatic int res_width(input int units, input int seq_w, input int e_w);
        return unit_width(units) + seq_w + e_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/find_sched_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | find_sched_fifo                                                       |
// | First-word-fall-through result FIFO with flush and occupancy count.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module find_sched_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    // Flush wins over any simultaneous push or pop
    assign w_push  = i_push && !w_full && !i_flush;
    assign w_pop   = i_pop && !w_empty && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/find_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | find_sched                                                            |
// | Round-robin collector of parallel find-unit results with best-energy. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module find_sched
    import find_sched_pkg::*;
#(
    parameter int SEQ_WIDTH      = 8,
    parameter int E_WIDTH        = 16,
    parameter int PARALLEL_UNITS = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int CLEAR_CYCLES   = 2,
    parameter int CYC_WIDTH      = 32
) (
    input  logic                                                 wb_clk_i,
    input  logic                                                 wb_rst_ni,
    input  logic                                                 i_start,
    input  logic                                                 i_abort,
    input  logic [PARALLEL_UNITS-1:0]                            i_done,
    input  logic [PARALLEL_UNITS*SEQ_WIDTH-1:0]                  i_seq,
    input  logic [PARALLEL_UNITS*E_WIDTH-1:0]                    i_e,
    output logic                                                 o_unit_rst,
    output logic                                                 o_busy,
    output logic                                                 o_all_done,
    output logic [SEQ_WIDTH-1:0]                                 o_best_seq,
    output logic [E_WIDTH-1:0]                                   o_best_e,
    output logic [unit_width(PARALLEL_UNITS)-1:0]                o_best_unit,
    output logic [CYC_WIDTH-1:0]                                 o_cycles,
    output logic                                                 o_res_valid,
    input  logic                                                 i_res_ready,
    output logic [res_width(PARALLEL_UNITS, SEQ_WIDTH, E_WIDTH)-1:0] o_res_data
);

    localparam int UW    = unit_width(PARALLEL_UNITS);
    localparam int RW    = res_width(PARALLEL_UNITS, SEQ_WIDTH, E_WIDTH);
    localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

    state_t                    r_state, w_state_nxt;
    logic [CNT_W-1:0]          r_clr_cnt;
    logic [PARALLEL_UNITS-1:0] r_collected;
    logic [UW-1:0]             r_rr_ptr;
    logic                      r_have_best;
    logic [SEQ_WIDTH-1:0]      r_best_seq;
    logic [E_WIDTH-1:0]        r_best_e;
    logic [UW-1:0]             r_best_unit;
    logic [CYC_WIDTH-1:0]      r_cycles;

    logic                      w_start_run;
    logic                      w_flush;
    logic [PARALLEL_UNITS-1:0] w_pending;
    logic [PARALLEL_UNITS-1:0] w_grant_vec;
    logic                      w_grant;
    logic [UW-1:0]             w_grant_idx;
    logic                      w_lo_hit, w_hi_hit;
    logic [UW-1:0]             w_lo_idx, w_hi_idx;
    logic [SEQ_WIDTH-1:0]      w_sel_seq;
    logic [E_WIDTH-1:0]        w_sel_e;
    logic [FCW-1:0]            w_fifo_count;
    logic                      w_fifo_full;

    assign w_fifo_full = (w_fifo_count == FCW'(FIFO_DEPTH));
    assign w_pending   = i_done & ~r_collected;

    // Round-robin: lowest pending index at or above the pointer, else lowest overall
    always_comb begin
        w_lo_hit    = 1'b0;
        w_hi_hit    = 1'b0;
        w_lo_idx    = '0;
        w_hi_idx    = '0;
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_grant_vec = '0;
        w_sel_seq   = '0;
        w_sel_e     = '0;
        for (int i = PARALLEL_UNITS - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_lo_hit = 1'b1;
                w_lo_idx = UW'(i);
                if (UW'(i) >= r_rr_ptr) begin
                    w_hi_hit = 1'b1;
                    w_hi_idx = UW'(i);
                end
            end
        end
        if (r_state == ST_RUN && !i_abort && !w_fifo_full && w_lo_hit) begin
            w_grant     = 1'b1;
            w_grant_idx = w_hi_hit ? w_hi_idx : w_lo_idx;
        end
        for (int i = 0; i < PARALLEL_UNITS; i++) begin
            if (w_grant && (w_grant_idx == UW'(i))) begin
                w_grant_vec[i] = 1'b1;
                w_sel_seq      = i_seq[i*SEQ_WIDTH +: SEQ_WIDTH];
                w_sel_e        = i_e[i*E_WIDTH +: E_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_run = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_state_nxt = ST_CLEAR;
                    w_start_run = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_flush     = 1'b1;
                end else if (r_clr_cnt == CNT_W'(CLEAR_CYCLES - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_flush     = 1'b1;
                end else if (&(r_collected | w_grant_vec)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_flush     = 1'b1;
                end else if (i_start) begin
                    w_state_nxt = ST_CLEAR;
                    w_start_run = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_start_run) w_flush = 1'b1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= ST_IDLE;
            r_clr_cnt   <= '0;
            r_collected <= '0;
            r_rr_ptr    <= '0;
            r_have_best <= 1'b0;
            r_best_seq  <= '0;
            r_best_e    <= '0;
            r_best_unit <= '0;
            r_cycles    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= (r_state == ST_CLEAR) ? r_clr_cnt + CNT_W'(1) : '0;
            if (w_start_run) begin
                r_collected <= '0;
                r_rr_ptr    <= '0;
                r_have_best <= 1'b0;
                r_best_seq  <= '0;
                r_best_e    <= '0;
                r_best_unit <= '0;
                r_cycles    <= '0;
            end else begin
                if (r_state == ST_RUN && r_cycles != '1) r_cycles <= r_cycles + CYC_WIDTH'(1);
                if (w_grant) begin
                    r_collected <= r_collected | w_grant_vec;
                    r_rr_ptr    <= (w_grant_idx == UW'(PARALLEL_UNITS - 1)) ? '0
                                                                             : w_grant_idx + UW'(1);
                    // Strict less-than: an equal energy keeps the earlier capture
                    if (!r_have_best || (w_sel_e < r_best_e)) begin
                        r_have_best <= 1'b1;
                        r_best_seq  <= w_sel_seq;
                        r_best_e    <= w_sel_e;
                        r_best_unit <= w_grant_idx;
                    end
                end
            end
        end
    end

    find_sched_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .i_flush (w_flush),
        .i_push  (w_grant),
        .i_data  ({w_grant_idx, w_sel_seq, w_sel_e}),
        .i_pop   (i_res_ready),
        .o_data  (o_res_data),
        .o_count (w_fifo_count)
    );

    assign o_unit_rst  = (r_state == ST_IDLE) || (r_state == ST_CLEAR);
    assign o_busy      = (r_state == ST_CLEAR) || (r_state == ST_RUN);
    assign o_all_done  = (r_state == ST_DONE);
    assign o_best_seq  = r_best_seq;
    assign o_best_e    = r_best_e;
    assign o_best_unit = r_best_unit;
    assign o_cycles    = r_cycles;
    assign o_res_valid = (w_fifo_count != '0);

endmodule
`default_nettype wire
